// File: rtl/jit_pkg.sv
// Shared definitions for the streaming ALU.
// Contents: data width, opcode encodings, S1 operand-pair record.
package jit_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    // 6 and 7 both pass A through.
    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_MUL   = 3'd2,
        OP_MAX   = 3'd3,
        OP_MIN   = 3'd4,
        OP_MAC   = 3'd5,
        OP_PASS  = 3'd6,
        OP_PASS2 = 3'd7
    } op_e;

    typedef struct packed {
        op_e   op;
        data_t a;
        data_t b;
    } pair_t;

endpackage

// File: rtl/jit_alu_op.sv
// Combinational operation unit: (op, a, b) -> res.
// For OP_MAC it returns the per-pair term that the top accumulates.
// Build option JIT_STREAM_ALU_MUL_EN:
//   defined   -> 32x32 multiplier; MUL = low 32 bits of a*b, MAC term = a*b
//   undefined -> no multiplier; MUL = 0, MAC term = a+b
// Ports: op (opcode), a, b (operands), res (result, wraps mod 2^32).
module jit_alu_op
    import jit_pkg::*;
(
    input  op_e   op,
    input  data_t a,
    input  data_t b,
    output data_t res
);

    data_t mul_res;
    data_t mac_term;

`ifdef JIT_STREAM_ALU_MUL_EN
    assign mul_res  = a * b;
    assign mac_term = mul_res;
`else
    assign mul_res  = '0;
    assign mac_term = a + b;
`endif

    always_comb begin
        res = a;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = mul_res;
            OP_MAX:  res = ($signed(a) > $signed(b)) ? a : b;
            OP_MIN:  res = ($signed(a) < $signed(b)) ? a : b;
            OP_MAC:  res = mac_term;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/jit_stream_alu.sv
// Two-stage streaming ALU joining operand streams A and B into result stream C.
// S1 registers the consumed pair; S2 registers the result. MAC reductions
// accumulate across pairs and emit one beat when the pair count reaches LEN.
// Build option JIT_STREAM_ALU_MUL_EN selects multiplier vs. adder for MUL/MAC.
// Ports:
//   ACLK, ARESETN           clock, async active-low reset
//   sA_* / sB_*             operand streams (ready/valid/data)
//   mC_*                    result stream
//   CONF                    opcode (see jit_pkg)
//   LEN                     pairs per MAC reduction (0 treated as 1)
//   BUSY                    any stage occupied or reduction in progress
module jit_stream_alu
    import jit_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    output logic              sA_tready,
    input  logic              sA_tvalid,
    input  logic [DATA_W-1:0] sA_tdata,
    output logic              sB_tready,
    input  logic              sB_tvalid,
    input  logic [DATA_W-1:0] sB_tdata,
    input  logic              mC_tready,
    output logic              mC_tvalid,
    output logic [DATA_W-1:0] mC_tdata,
    input  logic [2:0]        CONF,
    input  logic [LEN_W-1:0]  LEN,
    output logic              BUSY
);

    logic             en, fire;
    logic             s1_vld, s2_vld;
    pair_t            s1;
    logic [LEN_W-1:0] s1_len;
    data_t            s2_data;
    data_t            acc, acc_nxt, alu_res;
    logic [LEN_W-1:0] cnt, cnt_nxt, len_lat, len_eff;
    logic             mac_done;

    // Pipeline advances unless the output is held by backpressure.
    assign en   = !s2_vld || mC_tready;
    // Gating with ARESETN keeps readies low while reset is asserted.
    assign fire = en && sA_tvalid && sB_tvalid && ARESETN;

    assign sA_tready = fire;
    assign sB_tready = fire;
    assign mC_tvalid = s2_vld;
    assign mC_tdata  = s2_data;
    assign BUSY      = s1_vld || s2_vld || (cnt != '0);

    jit_alu_op u_op (
        .op  (s1.op),
        .a   (s1.a),
        .b   (s1.b),
        .res (alu_res)
    );

    // acc is always zero when cnt is zero, so no explicit restart term is needed.
    // LEN is taken from the first pair of a reduction and held in len_lat.
    always_comb begin
        len_eff  = (cnt == '0) ? ((s1_len == '0) ? LEN_W'(1) : s1_len) : len_lat;
        cnt_nxt  = cnt + LEN_W'(1);
        acc_nxt  = acc + alu_res;
        mac_done = (cnt_nxt == len_eff);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s1_vld  <= 1'b0;
            s1      <= '0;
            s1_len  <= '0;
            s2_vld  <= 1'b0;
            s2_data <= '0;
            acc     <= '0;
            cnt     <= '0;
            len_lat <= '0;
        end else if (en) begin
            s1_vld <= fire;
            if (fire) begin
                s1.op  <= op_e'(CONF);
                s1.a   <= sA_tdata;
                s1.b   <= sB_tdata;
                s1_len <= LEN;
            end
            s2_vld <= 1'b0;
            if (s1_vld) begin
                if (s1.op == OP_MAC) begin
                    if (mac_done) begin
                        s2_vld  <= 1'b1;
                        s2_data <= acc_nxt;
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        acc     <= acc_nxt;
                        cnt     <= cnt_nxt;
                        len_lat <= len_eff;
                    end
                end else begin
                    // Any non-MAC pair abandons a partial reduction.
                    s2_vld  <= 1'b1;
                    s2_data <= alu_res;
                    acc     <= '0;
                    cnt     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_jit_stream_alu.sv
module tb_jit_stream_alu;

    localparam int LEN_W = 16;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic              sA_tready, sA_tvalid;
    logic [31:0]       sA_tdata;
    logic              sB_tready, sB_tvalid;
    logic [31:0]       sB_tdata;
    logic              mC_tready, mC_tvalid;
    logic [31:0]       mC_tdata;
    logic [2:0]        CONF;
    logic [LEN_W-1:0]  LEN;
    logic              BUSY;

    int          n_cmp = 0;
    int          n_err = 0;
    int          sent;
    logic [31:0] held;
    logic [31:0] rx_q[$];

`ifdef JIT_STREAM_ALU_MUL_EN
    localparam logic [31:0] E_MUL   = 32'h2345_6780;
    localparam logic [31:0] E_MAC4  = 32'd100;
    localparam logic [31:0] E_MAC2  = 32'd26;
    localparam logic [31:0] E_LEN0  = 32'd12;
    localparam logic [31:0] E_LATCH = 32'd5;
    localparam logic [31:0] E_ABND  = 32'd13;
    localparam logic [31:0] E_RST   = 32'd2;
`else
    localparam logic [31:0] E_MUL   = 32'd0;
    localparam logic [31:0] E_MAC4  = 32'd36;
    localparam logic [31:0] E_MAC2  = 32'd14;
    localparam logic [31:0] E_LEN0  = 32'd7;
    localparam logic [31:0] E_LATCH = 32'd6;
    localparam logic [31:0] E_ABND  = 32'd10;
    localparam logic [31:0] E_RST   = 32'd4;
`endif

    always #5 ACLK = ~ACLK;

    jit_stream_alu #(.LEN_W(LEN_W)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .sA_tready (sA_tready),
        .sA_tvalid (sA_tvalid),
        .sA_tdata  (sA_tdata),
        .sB_tready (sB_tready),
        .sB_tvalid (sB_tvalid),
        .sB_tdata  (sB_tdata),
        .mC_tready (mC_tready),
        .mC_tvalid (mC_tvalid),
        .mC_tdata  (mC_tdata),
        .CONF      (CONF),
        .LEN       (LEN),
        .BUSY      (BUSY)
    );

    // Output beat log: a beat transfers on a rising edge with valid and ready high.
    always @(posedge ACLK)
        if (ARESETN && mC_tvalid && mC_tready) rx_q.push_back(mC_tdata);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [LEN_W-1:0] len);
        bit done;
        done = 1'b0;
        sA_tdata = a; sB_tdata = b; CONF = op; LEN = len;
        sA_tvalid = 1'b1; sB_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge ACLK);
            done = sA_tready;
        end
        #1;
        sA_tvalid = 1'b0; sB_tvalid = 1'b0;
        chk("handshake", 32'(done), 32'd1);
    endtask

    task automatic get_rx(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        d = 'x;
        for (int i = 0; i < 50 && rx_q.size() == 0; i++) @(negedge ACLK);
        if (rx_q.size() > 0) d = rx_q.pop_front();
        chk(tag, d, exp);
    endtask

    initial begin
        ARESETN = 1'b0; mC_tready = 1'b1;
        sA_tvalid = 1'b1; sB_tvalid = 1'b1;
        sA_tdata = 32'd1; sB_tdata = 32'd2; CONF = 3'd0; LEN = '0;

        // Reset state with both inputs offered
        repeat (3) @(negedge ACLK);
        chk("rst_tvalid", 32'(mC_tvalid), 32'd0);
        chk("rst_tdata",  mC_tdata,       32'd0);
        chk("rst_readyA", 32'(sA_tready), 32'd0);
        chk("rst_readyB", 32'(sB_tready), 32'd0);
        chk("rst_busy",   32'(BUSY),      32'd0);
        sA_tvalid = 1'b0; sB_tvalid = 1'b0;
        @(negedge ACLK) ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("rst_no_beat", 32'(rx_q.size()), 32'd0);

        // ADD latency: 5+7
        sA_tdata = 32'd5; sB_tdata = 32'd7; CONF = 3'd0;
        sA_tvalid = 1'b1; sB_tvalid = 1'b1;
        #1 chk("add_ready", 32'(sA_tready), 32'd1);
        @(posedge ACLK); #1;
        sA_tvalid = 1'b0; sB_tvalid = 1'b0;
        @(negedge ACLK) chk("add_lat1_vld", 32'(mC_tvalid), 32'd0);
        @(negedge ACLK) chk("add_lat2_vld", 32'(mC_tvalid), 32'd1);
        chk("add_data", mC_tdata, 32'd12);
        get_rx("add_beat", 32'd12);
        @(negedge ACLK) chk("add_single", 32'(mC_tvalid), 32'd0);

        // Arithmetic / signed compare / pass
        xfer(32'd3, 32'hFFFF_FFFF, 3'd1, '0);  get_rx("sub", 32'd4);
        xfer(32'd3, 32'hFFFF_FFFF, 3'd3, '0);  get_rx("max", 32'd3);
        xfer(32'd3, 32'hFFFF_FFFF, 3'd4, '0);  get_rx("min", 32'hFFFF_FFFF);
        xfer(32'hFFFF_FFFF, 32'd2, 3'd0, '0);  get_rx("add_wrap", 32'd1);
        xfer(32'h1234_5678, 32'h10, 3'd2, '0); get_rx("mul", E_MUL);
        xfer(32'hDEAD_BEEF, 32'd9, 3'd6, '0);  get_rx("pass6", 32'hDEAD_BEEF);
        xfer(32'hCAFE_0001, 32'd9, 3'd7, '0);  get_rx("pass7", 32'hCAFE_0001);

        // MAC LEN=4
        xfer(32'd1, 32'd2, 3'd5, 16'd4);
        xfer(32'd3, 32'd4, 3'd5, 16'd4);
        xfer(32'd5, 32'd6, 3'd5, 16'd4);
        repeat (4) @(negedge ACLK);
        chk("mac_no_early", 32'(rx_q.size()), 32'd0);
        chk("mac_busy",     32'(BUSY),        32'd1);
        xfer(32'd7, 32'd8, 3'd5, 16'd4);
        get_rx("mac4", E_MAC4);
        repeat (3) @(negedge ACLK);
        chk("mac_idle", 32'(BUSY), 32'd0);
        xfer(32'd2, 32'd3, 3'd5, 16'd2);
        xfer(32'd4, 32'd5, 3'd5, 16'd2);
        get_rx("mac_fresh", E_MAC2);

        // LEN=0 behaves as 1
        xfer(32'd3, 32'd4, 3'd5, 16'd0);
        get_rx("mac_len0", E_LEN0);

        // LEN latched on first pair
        xfer(32'd1, 32'd1, 3'd5, 16'd2);
        xfer(32'd2, 32'd2, 3'd5, 16'd5);
        get_rx("mac_latch", E_LATCH);
        repeat (4) @(negedge ACLK);
        chk("latch_idle", 32'(BUSY), 32'd0);
        chk("latch_no_extra", 32'(rx_q.size()), 32'd0);

        // Non-MAC op abandons the partial sum
        xfer(32'd1, 32'd1, 3'd5, 16'd3);
        xfer(32'd10, 32'd20, 3'd0, 16'd3);
        get_rx("abandon_add", 32'd30);
        repeat (3) @(negedge ACLK);
        chk("abandon_idle", 32'(BUSY), 32'd0);
        xfer(32'd2, 32'd2, 3'd5, 16'd2);
        xfer(32'd3, 32'd3, 3'd5, 16'd2);
        get_rx("abandon_mac", E_ABND);

        // Backpressure: 10 ADD pairs, ready low for 5 cycles
        @(posedge ACLK); #1;
        sent = 0; held = '0;
        CONF = 3'd0; sA_tdata = 32'd1; sB_tdata = 32'd16;
        sA_tvalid = 1'b1; sB_tvalid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            mC_tready = !(c >= 4 && c < 9);
            @(negedge ACLK);
            if (c == 4) held = mC_tdata;
            if (c >= 5 && c < 9) begin
                chk("bp_readyA", 32'(sA_tready), 32'd0);
                chk("bp_readyB", 32'(sB_tready), 32'd0);
                chk("bp_valid",  32'(mC_tvalid), 32'd1);
                chk("bp_hold",   mC_tdata,       held);
            end
            @(posedge ACLK);
            if (sA_tvalid && sA_tready) sent++;
            #1;
            if (sent < 10) begin
                sA_tdata = 32'(sent + 1);
                sB_tdata = 32'((sent + 1) * 16);
            end else begin
                sA_tvalid = 1'b0; sB_tvalid = 1'b0;
            end
        end
        mC_tready = 1'b1;
        chk("bp_sent",  32'(sent),        32'd10);
        chk("bp_count", 32'(rx_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) get_rx("bp_order", 32'((i + 1) * 17));

        // Join: A alone for 4 cycles
        @(posedge ACLK); #1;
        sA_tdata = 32'd20; sB_tdata = 32'd22; CONF = 3'd0;
        sA_tvalid = 1'b1; sB_tvalid = 1'b0;
        repeat (4) begin
            @(negedge ACLK);
            chk("join_readyA", 32'(sA_tready), 32'd0);
            chk("join_readyB", 32'(sB_tready), 32'd0);
        end
        @(posedge ACLK); #1;
        sB_tvalid = 1'b1;
        #1 chk("join_both", 32'(sA_tready & sB_tready), 32'd1);
        @(posedge ACLK); #1;
        sA_tvalid = 1'b0; sB_tvalid = 1'b0;
        get_rx("join_beat", 32'd42);
        repeat (4) @(negedge ACLK);
        chk("join_once", 32'(rx_q.size()), 32'd0);

        // Reset mid-reduction
        xfer(32'd1, 32'd1, 3'd5, 16'd4);
        xfer(32'd2, 32'd2, 3'd5, 16'd4);
        @(negedge ACLK) chk("mid_busy", 32'(BUSY), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(BUSY),      32'd0);
        chk("mid_rst_valid", 32'(mC_tvalid), 32'd0);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (6) @(negedge ACLK);
        chk("mid_no_beat", 32'(rx_q.size()), 32'd0);
        chk("mid_idle",    32'(BUSY),        32'd0);
        xfer(32'd1, 32'd1, 3'd5, 16'd2);
        xfer(32'd1, 32'd1, 3'd5, 16'd2);
        get_rx("mid_fresh", E_RST);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jit_stream_alu.md
JIT_STREAM_ALU -- requirements
Module: jit_stream_alu

Interface
REQ-001 Parameter LEN_W, default 16: width of the reduction length port.
REQ-002 ACLK  input  1  single clock; all state updates on the rising edge.
REQ-003 ARESETN  input  1  asynchronous, active-low reset.
REQ-004 sA_tready/sA_tvalid/sA_tdata  out/in/in  1/1/32  operand A stream, fed by the coupler's AccOutA.
REQ-005 sB_tready/sB_tvalid/sB_tdata  out/in/in  1/1/32  operand B stream, fed by the coupler's AccOutB.
REQ-006 mC_tready/mC_tvalid/mC_tdata  in/out/out  1/1/32  result stream, drives the coupler's AccInC.
REQ-007 CONF  input  3  operation select: 0 ADD, 1 SUB (A-B), 2 MUL (low 32 bits), 3 MAX signed, 4 MIN signed, 5 MAC reduce, 6-7 PASS A.
REQ-008 LEN  input  LEN_W  number of operand pairs per MAC reduction; 0 is treated as 1.
REQ-009 BUSY  output  1  high while any pipeline stage holds data or a reduction is partially accumulated.

Function
REQ-010 The block shall join A and B: a pair is consumed only when sA_tvalid and sB_tvalid are both high and the pipeline enable EN is high.
REQ-011 EN shall equal (not S2 valid) or mC_tready; sA_tready and sB_tready shall both equal EN and sA_tvalid and sB_tvalid.
REQ-012 A beat on one input with no beat on the other shall never be consumed.
REQ-013 Stage S1 shall register A, B, CONF and LEN on each consumed pair; S1 valid clears when EN is high and no pair is consumed.
REQ-014 Stage S2 shall register the computed result; mC_tdata shall be S2 data and mC_tvalid S2 valid.
REQ-015 For non-MAC operations, latency shall be exactly 2 cycles from input handshake to mC_tvalid, at one result per cycle sustained throughput.
REQ-016 When EN is low, S1 and S2 shall hold their contents; mC_tdata shall not change while mC_tvalid is high and mC_tready is low.
REQ-017 ADD/SUB/MUL shall wrap modulo 2^32; MAX/MIN shall compare as two's-complement signed.
REQ-018 MAC shall accumulate A*B (low 32 bits, wrapping) into a 32-bit accumulator and count pairs; S2 valid is asserted only on the pair whose count reaches the latched LEN, with data equal to the full sum.
REQ-019 On MAC completion the accumulator and count shall clear in the same cycle, so the next pair starts a new reduction.
REQ-020 LEN shall be latched on the first pair of a reduction; later LEN changes shall not affect that reduction.
REQ-021 A CONF value other than 5 arriving mid-reduction shall abandon the partial sum (accumulator and count cleared) and that pair shall be processed as its own operation.
REQ-022 BUSY shall be low only when S1 and S2 are empty and the MAC count is zero.

Reset
REQ-023 While ARESETN is low: mC_tvalid=0, mC_tdata=0, sA_tready=0, sB_tready=0, BUSY=0, S1/S2 valid=0, accumulator=0, count=0.
REQ-024 Reset asserted mid-operation shall discard all in-flight data and partial sums; no output beat is produced for them after release.

Configuration
REQ-025 Macro JIT_STREAM_ALU_MUL_EN defined: MUL and MAC shall use a 32x32 multiplier as specified.
REQ-026 Macro undefined: no multiplier is instantiated; MUL shall produce 0 and MAC shall accumulate A+B instead of A*B, with identical timing.

Structure
REQ-027 Opcode encodings (ADD..PASS) and the 32-bit data width constant shall reside in the shared package jit_pkg.
REQ-028 The combinational operation unit (opcode, A, B -> result) shall be a sub-module named jit_alu_op; pipeline, join and MAC control stay in jit_stream_alu.

Verification
REQ-029 ADD: A=5, B=7 both valid, mC_tready=1 -> mC_tdata=12 with mC_tvalid exactly 2 cycles after the handshake.
REQ-030 SUB/MAX: A=3, B=0xFFFFFFFF -> SUB gives 4; MAX gives 3.
REQ-031 MAC: LEN=4, pairs (1,2),(3,4),(5,6),(7,8) -> one output beat 100; no beat after pairs 1-3; next reduction starts from 0.
REQ-032 Backpressure: 10 ADD pairs streamed with mC_tready held low 5 cycles -> input readies drop, no beat lost or duplicated, results in order, tdata stable while stalled.
REQ-033 Join: sA_tvalid high alone for 4 cycles then sB_tvalid rises -> no ready asserted until both valid; exactly one result produced.
REQ-034 Reset during MAC after 2 of LEN=4 pairs -> after release, a fresh LEN=2 reduction of (1,1),(1,1) outputs 2.
